// File: rtl/neo_port_if.sv
// Host request port and cartridge port bus seen by the port-access sequencer.
// master is the sequencer's view; slave is the host/cartridge-mux side.
interface neo_port_if;
    logic        REQ;
    logic        WR;
    logic [18:0] ADDR;
    logic [15:0] WDATA;
    logic [1:0]  BE;
    logic        BUSY;
    logic        ACK;
    logic        ERR;
    logic [15:0] RDATA;
    logic        BUS_REQ;
    logic        BUS_GNT;
    logic [18:0] P_ADDR;
    logic [15:0] P_DOUT;
    logic        P_DOE;
    logic [15:0] P_DIN;
    logic        nPORTOEL;
    logic        nPORTOEU;
    logic        nPORTWEL;
    logic        nPORTWEU;

    modport master (
        input  REQ, WR, ADDR, WDATA, BE, BUS_GNT, P_DIN,
        output BUSY, ACK, ERR, RDATA, BUS_REQ, P_ADDR, P_DOUT, P_DOE,
               nPORTOEL, nPORTOEU, nPORTWEL, nPORTWEU
    );

    modport slave (
        output REQ, WR, ADDR, WDATA, BE, BUS_GNT, P_DIN,
        input  BUSY, ACK, ERR, RDATA, BUS_REQ, P_ADDR, P_DOUT, P_DOE,
               nPORTOEL, nPORTOEU, nPORTWEL, nPORTWEU
    );
endinterface

// File: rtl/neo_port_master.sv
// Issues single 16-bit P-ROM port accesses for a non-68K host, with
// programmable setup/strobe/hold timing and bus request/grant arbitration.
//
// state  | meaning
// IDLE   | waiting for a host REQ
// ARB    | BUS_REQ high, waiting for BUS_GNT or timeout
// SETUP  | address/data driven, strobes high
// STROBE | lane strobes low
// HOLD   | strobes high, address/data held
// DONE   | ACK pulse (delayed one cycle for BE=00 and grant loss)
module neo_port_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 6,
    parameter int HOLD_CYC   = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic       CLK_48M,
    input  logic       nRESET,
    neo_port_if.master bus_io
);
    localparam int S_EFF = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int W_EFF = (STROBE_CYC < 2) ? 2 : STROBE_CYC;
    localparam int H_EFF = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
    localparam int T_EFF = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int M1    = (S_EFF > W_EFF) ? S_EFF : W_EFF;
    localparam int M2    = (M1 > H_EFF) ? M1 : H_EFF;
    localparam int CMAX  = (M2 > T_EFF) ? M2 : T_EFF;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [CW-1:0] S_LOAD = CW'(S_EFF - 1);
    localparam logic [CW-1:0] W_LOAD = CW'(W_EFF - 1);
    localparam logic [CW-1:0] H_LOAD = CW'(H_EFF - 1);
    localparam logic [CW-1:0] T_LOAD = CW'(T_EFF);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARB    = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [18:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [1:0]    be_q, be_d;
    logic          fail_q, fail_d;
    logic          busy_q, busy_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          bus_req_q, bus_req_d;
    logic [18:0]   p_addr_q, p_addr_d;
    logic [15:0]   p_dout_q, p_dout_d;
    logic          p_doe_q, p_doe_d;
    logic          oel_n_q, oel_n_d;
    logic          oeu_n_q, oeu_n_d;
    logic          wel_n_q, wel_n_d;
    logic          weu_n_q, weu_n_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        fail_d    = fail_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        bus_req_d = bus_req_q;
        p_addr_d  = p_addr_q;
        p_dout_d  = p_dout_q;
        p_doe_d   = p_doe_q;
        oel_n_d   = oel_n_q;
        oeu_n_d   = oeu_n_q;
        wel_n_d   = wel_n_q;
        weu_n_d   = weu_n_q;

        case (state_q)
            ST_IDLE: begin
                if (bus_io.REQ) begin
                    wr_d    = bus_io.WR;
                    addr_d  = bus_io.ADDR;
                    wdata_d = bus_io.WDATA;
                    be_d    = bus_io.BE;
                    fail_d  = 1'b0;
                    busy_d  = 1'b1;
                    if (bus_io.BE == 2'b00) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_ARB;
                        bus_req_d = 1'b1;
                        cnt_d     = T_LOAD;
                    end
                end
            end
            ST_ARB: begin
                if (bus_io.BUS_GNT) begin
                    state_d  = ST_SETUP;
                    cnt_d    = S_LOAD;
                    p_addr_d = addr_q;
                    if (wr_q) begin
                        p_dout_d = wdata_q;
                        p_doe_d  = 1'b1;
                    end
                end else if (cnt_q == '0) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                if (!bus_io.BUS_GNT) begin
                    // Grant lost: release the bus now, report the error next cycle.
                    state_d   = ST_DONE;
                    fail_d    = 1'b1;
                    bus_req_d = 1'b0;
                    p_doe_d   = 1'b0;
                    oel_n_d   = 1'b1;
                    oeu_n_d   = 1'b1;
                    wel_n_d   = 1'b1;
                    weu_n_d   = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    case (state_q)
                        ST_SETUP: begin
                            state_d = ST_STROBE;
                            cnt_d   = W_LOAD;
                            oel_n_d = ~(~wr_q & be_q[0]);
                            oeu_n_d = ~(~wr_q & be_q[1]);
                            wel_n_d = ~(wr_q & be_q[0]);
                            weu_n_d = ~(wr_q & be_q[1]);
                        end
                        ST_STROBE: begin
                            state_d = ST_HOLD;
                            cnt_d   = H_LOAD;
                            oel_n_d = 1'b1;
                            oeu_n_d = 1'b1;
                            wel_n_d = 1'b1;
                            weu_n_d = 1'b1;
                            if (!wr_q) begin
                                rdata_d = {be_q[1] ? bus_io.P_DIN[15:8] : 8'h00,
                                           be_q[0] ? bus_io.P_DIN[7:0]  : 8'h00};
                            end
                        end
                        default: begin
                            state_d   = ST_DONE;
                            bus_req_d = 1'b0;
                            p_doe_d   = 1'b0;
                            ack_d     = 1'b1;
                        end
                    endcase
                end
            end
            ST_DONE: begin
                if (ack_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    ack_d = 1'b1;
                    err_d = fail_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_48M or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            fail_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            bus_req_q <= 1'b0;
            p_addr_q  <= '0;
            p_dout_q  <= '0;
            p_doe_q   <= 1'b0;
            oel_n_q   <= 1'b1;
            oeu_n_q   <= 1'b1;
            wel_n_q   <= 1'b1;
            weu_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            fail_q    <= fail_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            bus_req_q <= bus_req_d;
            p_addr_q  <= p_addr_d;
            p_dout_q  <= p_dout_d;
            p_doe_q   <= p_doe_d;
            oel_n_q   <= oel_n_d;
            oeu_n_q   <= oeu_n_d;
            wel_n_q   <= wel_n_d;
            weu_n_q   <= weu_n_d;
        end
    end

    assign bus_io.BUSY     = busy_q;
    assign bus_io.ACK      = ack_q;
    assign bus_io.ERR      = err_q;
    assign bus_io.RDATA    = rdata_q;
    assign bus_io.BUS_REQ  = bus_req_q;
    assign bus_io.P_ADDR   = p_addr_q;
    assign bus_io.P_DOUT   = p_dout_q;
    assign bus_io.P_DOE    = p_doe_q;
    assign bus_io.nPORTOEL = oel_n_q;
    assign bus_io.nPORTOEU = oeu_n_q;
    assign bus_io.nPORTWEL = wel_n_q;
    assign bus_io.nPORTWEU = weu_n_q;
endmodule

// File: tb/tb_neo_port_master.sv
// Scoreboard bench for neo_port_master: stimulus queues expected responses,
// a negedge monitor compares them when ACK appears.
module tb_neo_port_master;
    logic CLK_48M = 1'b0;
    logic nRESET  = 1'b1;
    int   cyc     = 0;

    neo_port_if bus();

    neo_port_master #(.TIMEOUT(16)) dut (
        .CLK_48M (CLK_48M),
        .nRESET  (nRESET),
        .bus_io  (bus)
    );

    typedef struct {
        int req_cyc; int lat; int err; int rdata;
        int oel; int oeu; int wel; int weu; int doe; int fall; int breq;
    } exp_t;
    typedef struct { logic [127:0] name; int act; int exp; } obs_t;

    exp_t sb[$];
    obs_t obs_q[$];
    int checks = 0, failures = 0, ack_seen = 0;
    int n_oel = 0, n_oeu = 0, n_wel = 0, n_weu = 0, n_doe = 0, n_breq = 0, fall_cyc = -1;

    always #5 CLK_48M = ~CLK_48M;
    always @(posedge CLK_48M) cyc <= cyc + 1;

    task automatic cmp(input logic [127:0] name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %0s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk(input logic [127:0] name, input int act, input int exp);
        obs_t o;
        o.name = name; o.act = act; o.exp = exp;
        obs_q.push_back(o);
    endtask

    function automatic exp_t mk(int lat, int err, int rdata, int oel, int oeu,
                                int wel, int weu, int doe, int fall, int breq);
        exp_t e;
        e.req_cyc = 0; e.lat = lat; e.err = err; e.rdata = rdata;
        e.oel = oel; e.oeu = oeu; e.wel = wel; e.weu = weu;
        e.doe = doe; e.fall = fall; e.breq = breq;
        return e;
    endfunction

    // Monitor: sole owner of the check/failure counters.
    always @(negedge CLK_48M) begin : mon
        obs_t o;
        exp_t e;
        logic oe_low, we_low;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            cmp(o.name, o.act, o.exp);
        end
        if (!nRESET) begin
            n_oel = 0; n_oeu = 0; n_wel = 0; n_weu = 0; n_doe = 0; n_breq = 0; fall_cyc = -1;
        end else begin
            oe_low = !bus.nPORTOEL || !bus.nPORTOEU;
            we_low = !bus.nPORTWEL || !bus.nPORTWEU;
            if (!bus.nPORTOEL) n_oel++;
            if (!bus.nPORTOEU) n_oeu++;
            if (!bus.nPORTWEL) n_wel++;
            if (!bus.nPORTWEU) n_weu++;
            if (bus.P_DOE) n_doe++;
            if (bus.BUS_REQ) n_breq++;
            if ((oe_low || we_low) && fall_cyc < 0) fall_cyc = cyc;
            if (oe_low || we_low) cmp("oe_we_overlap", int'(oe_low && we_low), 0);
            if (bus.ACK) begin
                if (sb.size() == 0) begin
                    cmp("unexpected_ack", 1, 0);
                end else begin
                    e = sb.pop_front();
                    cmp("ack_latency", cyc - e.req_cyc, e.lat);
                    cmp("err", int'(bus.ERR), e.err);
                    cmp("rdata", int'(bus.RDATA), e.rdata);
                    cmp("oel_low_cycles", n_oel, e.oel);
                    cmp("oeu_low_cycles", n_oeu, e.oeu);
                    cmp("wel_low_cycles", n_wel, e.wel);
                    cmp("weu_low_cycles", n_weu, e.weu);
                    cmp("doe_cycles", n_doe, e.doe);
                    cmp("strobe_fall", (fall_cyc < 0) ? -1 : fall_cyc - e.req_cyc, e.fall);
                    cmp("bus_req_cycles", n_breq, e.breq);
                end
                ack_seen++;
                n_oel = 0; n_oeu = 0; n_wel = 0; n_weu = 0; n_doe = 0; n_breq = 0; fall_cyc = -1;
            end
        end
    end

    task automatic start_req(input logic wr, input logic [18:0] a, input logic [15:0] d,
                             input logic [1:0] be, input exp_t e);
        @(negedge CLK_48M);
        bus.REQ = 1'b1; bus.WR = wr; bus.ADDR = a; bus.WDATA = d; bus.BE = be;
        @(posedge CLK_48M);
        #1;
        bus.REQ = 1'b0;
        e.req_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int n0);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge CLK_48M);
            if (ack_seen > n0) got = 1'b1;
        end
        if (!got) chk("ack_wait", 0, 1);
    endtask

    function automatic int strobes();
        return int'({bus.nPORTOEU, bus.nPORTOEL, bus.nPORTWEU, bus.nPORTWEL});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bus.REQ = 1'b0; bus.WR = 1'b0; bus.ADDR = '0; bus.WDATA = '0; bus.BE = '0;
        bus.BUS_GNT = 1'b1; bus.P_DIN = '0;
        #2 nRESET = 1'b0;
        #20;
        chk("rst_strobes", strobes(), 15);
        chk("rst_bus_req", int'(bus.BUS_REQ), 0);
        chk("rst_p_doe", int'(bus.P_DOE), 0);
        chk("rst_ack", int'(bus.ACK), 0);
        chk("rst_err", int'(bus.ERR), 0);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_rdata", int'(bus.RDATA), 0);
        chk("rst_p_addr", int'(bus.P_ADDR), 0);
        chk("rst_p_dout", int'(bus.P_DOUT), 0);
        @(negedge CLK_48M);
        nRESET = 1'b1;
        repeat (2) @(posedge CLK_48M);

        // Bank write, grant tied high
        n0 = ack_seen;
        start_req(1'b1, 19'h7FFF8, 16'h0020, 2'b11, mk(11, 0, 'h0000, 0, 0, 6, 6, 10, 3, 11));
        wait_ack(n0);
        chk("wr_p_addr", int'(bus.P_ADDR), 'h7FFF8);
        chk("wr_p_dout", int'(bus.P_DOUT), 'h0020);

        // ID read, issued in the cycle after the previous ACK
        n0 = ack_seen;
        bus.P_DIN = 16'h9A37;
        start_req(1'b0, 19'h7F223, 16'h0000, 2'b11, mk(11, 0, 'h9A37, 6, 6, 0, 0, 0, 3, 11));
        wait_ack(n0);

        // Lower-lane read
        n0 = ack_seen;
        bus.P_DIN = 16'hABCD;
        start_req(1'b0, 19'h7F224, 16'h0000, 2'b01, mk(11, 0, 'h00CD, 6, 0, 0, 0, 0, 3, 11));
        wait_ack(n0);

        // No lanes enabled: immediate completion, no bus cycle
        n0 = ack_seen;
        bus.P_DIN = 16'h1111;
        start_req(1'b0, 19'h7F224, 16'h0000, 2'b00, mk(1, 0, 'h00CD, 0, 0, 0, 0, 0, -1, 0));
        wait_ack(n0);

        // Grant never arrives
        n0 = ack_seen;
        bus.BUS_GNT = 1'b0;
        start_req(1'b0, 19'h00010, 16'h0000, 2'b11, mk(17, 1, 'h00CD, 0, 0, 0, 0, 0, -1, 17));
        wait_ack(n0);
        chk("bus_req_after_to", int'(bus.BUS_REQ), 0);
        bus.BUS_GNT = 1'b1;
        repeat (2) @(posedge CLK_48M);

        // Grant revoked in the third strobe cycle; a REQ while busy is ignored
        n0 = ack_seen;
        start_req(1'b1, 19'h7FFF8, 16'h0003, 2'b11, mk(7, 1, 'h00CD, 0, 0, 3, 3, 5, 3, 6));
        repeat (3) @(negedge CLK_48M);
        bus.REQ = 1'b1; bus.WR = 1'b0; bus.BE = 2'b11;
        @(negedge CLK_48M);
        bus.REQ = 1'b0;
        repeat (2) @(negedge CLK_48M);
        bus.BUS_GNT = 1'b0;
        wait_ack(n0);
        bus.BUS_GNT = 1'b1;
        repeat (20) @(posedge CLK_48M);
        chk("no_extra_ack", ack_seen, n0 + 1);
        chk("idle_after_revoke", int'(bus.BUSY), 0);

        // Asynchronous reset in the middle of a write strobe
        n0 = ack_seen;
        start_req(1'b1, 19'h12345, 16'hBEEF, 2'b11, mk(11, 0, 0, 0, 0, 6, 6, 10, 3, 11));
        repeat (6) @(negedge CLK_48M);
        chk("we_low_before_rst", int'({bus.nPORTWEU, bus.nPORTWEL}), 0);
        #1 nRESET = 1'b0;
        #1;
        chk("midrst_strobes", strobes(), 15);
        chk("midrst_bus_req", int'(bus.BUS_REQ), 0);
        chk("midrst_p_doe", int'(bus.P_DOE), 0);
        chk("midrst_busy", int'(bus.BUSY), 0);
        sb.delete();
        repeat (3) @(posedge CLK_48M);
        @(negedge CLK_48M);
        nRESET = 1'b1;
        repeat (5) @(posedge CLK_48M);
        chk("no_ack_on_reset", ack_seen, n0);

        // Normal read after reset release
        n0 = ack_seen;
        bus.P_DIN = 16'h5AC3;
        start_req(1'b0, 19'h7F223, 16'h0000, 2'b11, mk(11, 0, 'h5AC3, 6, 6, 0, 0, 0, 3, 11));
        wait_ack(n0);

        repeat (3) @(negedge CLK_48M);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
